// File: rtl/sipo_deserializer_if.sv
// Serial-in and parallel-out handshake bundle for sipo_deserializer.
// The master side feeds bits and accepts words; the slave side is the deserializer.
interface sipo_deserializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             serial_in;
  logic             serial_valid;
  logic [WIDTH-1:0] parallel_out;
  logic             parallel_valid;
  logic             parallel_ready;

  modport master (
    output serial_in,
    output serial_valid,
    output parallel_ready,
    input  parallel_out,
    input  parallel_valid
  );

  modport slave (
    input  serial_in,
    input  serial_valid,
    input  parallel_ready,
    output parallel_out,
    output parallel_valid
  );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out receiver: assembles WIDTH-bit words from a qualified bit
// stream and presents them through a valid/ready holding register with sticky overrun.
module sipo_deserializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  sipo_deserializer_if.slave       bus,
  input  logic                     sync_clear,
  output logic                     overrun,
  input  logic                     overrun_clear,
  output logic [$clog2(WIDTH)-1:0] bit_count,
  output logic                     busy
);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_next;
  logic [WIDTH-1:0] hold_q;
  logic             hold_valid_q;
  logic             accept;
  logic             complete;
  logic             drain;
  logic             load;

  always_comb begin
    shift_next = shift_q;
    if (LSB_FIRST) begin
      shift_next = {bus.serial_in, shift_q[WIDTH-1:1]};
    end else begin
      shift_next = {shift_q[WIDTH-2:0], bus.serial_in};
    end
  end

  assign accept   = bus.serial_valid && !sync_clear;
  assign complete = accept && (bit_count == LAST_BIT);
  assign drain    = hold_valid_q && bus.parallel_ready;
  // The holding register can take a new word if empty or emptying this edge.
  assign load     = complete && (!hold_valid_q || bus.parallel_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q   <= '0;
      bit_count <= '0;
    end else if (sync_clear) begin
      shift_q   <= '0;
      bit_count <= '0;
    end else if (bus.serial_valid) begin
      shift_q   <= shift_next;
      bit_count <= complete ? '0 : bit_count + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else if (load) begin
      hold_q       <= shift_next;
      hold_valid_q <= 1'b1;
    end else if (drain) begin
      hold_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (complete && !load) begin
      overrun <= 1'b1;
    end else if (overrun_clear) begin
      overrun <= 1'b0;
    end
  end

  assign bus.parallel_out   = hold_q;
  assign bus.parallel_valid = hold_valid_q;
  assign busy               = (bit_count != '0);
endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed plus randomized checks of two sipo_deserializer instances (LSB and MSB
// first) fed the same bit stream, against a bit-list reference model.
module tb_sipo_deserializer;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sync_clear = 1'b0;
  logic       overrun_clear = 1'b0;
  logic       ovr0, ovr1, busy0, busy1;
  logic [2:0] bc0, bc1;

  int checks = 0;
  int errors = 0;

  // Reference model: received bits of the current partial word plus holding state.
  int unsigned pbits [8];
  int unsigned pcnt = 0;
  bit          m_valid = 1'b0;
  bit          m_ovr = 1'b0;
  int unsigned m_out_lsb = 0;
  int unsigned m_out_msb = 0;

  sipo_deserializer_if #(.WIDTH(8)) bus0 ();
  sipo_deserializer_if #(.WIDTH(8)) bus1 ();

  sipo_deserializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0), .sync_clear(sync_clear),
    .overrun(ovr0), .overrun_clear(overrun_clear), .bit_count(bc0), .busy(busy0)
  );

  sipo_deserializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1), .sync_clear(sync_clear),
    .overrun(ovr1), .overrun_clear(overrun_clear), .bit_count(bc1), .busy(busy1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " valid0"}, {31'd0, bus0.parallel_valid}, {31'd0, m_valid});
    chk({tag, " valid1"}, {31'd0, bus1.parallel_valid}, {31'd0, m_valid});
    chk({tag, " out0"}, {24'd0, bus0.parallel_out}, m_out_lsb);
    chk({tag, " out1"}, {24'd0, bus1.parallel_out}, m_out_msb);
    chk({tag, " overrun0"}, {31'd0, ovr0}, {31'd0, m_ovr});
    chk({tag, " overrun1"}, {31'd0, ovr1}, {31'd0, m_ovr});
    chk({tag, " bit_count0"}, {29'd0, bc0}, pcnt);
    chk({tag, " bit_count1"}, {29'd0, bc1}, pcnt);
    chk({tag, " busy0"}, {31'd0, busy0}, {31'd0, pcnt != 0});
    chk({tag, " busy1"}, {31'd0, busy1}, {31'd0, pcnt != 0});
  endtask

  task automatic model_reset();
    pcnt = 0; m_valid = 1'b0; m_ovr = 1'b0; m_out_lsb = 0; m_out_msb = 0;
  endtask

  // One clock: drive inputs, advance the model by the edge rules, check #1 after.
  task automatic cycle(input bit sin, input bit sv, input bit sc, input bit rdy,
                       input bit oc, input string tag);
    bit drain, ovr_ev, loaded;
    int unsigned wl, wm;
    bus0.serial_in = sin;  bus1.serial_in = sin;
    bus0.serial_valid = sv; bus1.serial_valid = sv;
    bus0.parallel_ready = rdy; bus1.parallel_ready = rdy;
    sync_clear = sc;
    overrun_clear = oc;
    @(posedge clk);
    drain = m_valid && rdy;
    ovr_ev = 1'b0;
    loaded = 1'b0;
    if (sc) begin
      pcnt = 0;
    end else if (sv) begin
      pbits[pcnt] = sin;
      pcnt++;
      if (pcnt == 8) begin
        pcnt = 0;
        wl = 0; wm = 0;
        for (int i = 0; i < 8; i++) begin
          wl += pbits[i] << i;
          wm += pbits[i] << (7 - i);
        end
        if (!m_valid || rdy) begin
          m_out_lsb = wl; m_out_msb = wm; loaded = 1'b1;
        end else begin
          ovr_ev = 1'b1;
        end
      end
    end
    if (loaded) m_valid = 1'b1;
    else if (drain) m_valid = 1'b0;
    if (ovr_ev) m_ovr = 1'b1;
    else if (oc) m_ovr = 1'b0;
    #1;
    check_all(tag);
  endtask

  task automatic send_word(input logic [7:0] w, input bit lsb, input bit rdy_body,
                           input bit rdy_last, input string tag);
    logic [7:0] wv;
    wv = w;
    for (int i = 0; i < 8; i++) begin
      cycle(lsb ? wv[i] : wv[7 - i], 1'b1, 1'b0, (i == 7) ? rdy_last : rdy_body, 1'b0, tag);
    end
  endtask

  initial begin
    bus0.serial_in = 1'b0; bus1.serial_in = 1'b0;
    bus0.serial_valid = 1'b0; bus1.serial_valid = 1'b0;
    bus0.parallel_ready = 1'b0; bus1.parallel_ready = 1'b0;

    // Reset state
    @(posedge clk);
    #1;
    check_all("reset");
    #2 reset_n = 1'b1;

    // Single word 0xA5, LSB first, ready high: valid for exactly one cycle
    send_word(8'hA5, 1'b1, 1'b1, 1'b1, "a5");
    chk("a5 word", {24'd0, bus0.parallel_out}, 32'hA5);
    chk("a5 valid", {31'd0, bus0.parallel_valid}, 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "a5 drain");
    chk("a5 one cycle", {31'd0, bus0.parallel_valid}, 32'd0);

    // MSB order with gaps on every other cycle
    for (int i = 7; i >= 0; i--) begin
      cycle((8'h3C >> i) & 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "gap bit");
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "gap idle");
    end
    chk("msb word", {24'd0, bus1.parallel_out}, 32'h3C);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "msb drain");

    // Backpressure: second word dropped, overrun set, first word held
    send_word(8'h11, 1'b1, 1'b0, 1'b0, "bp first");
    send_word(8'h22, 1'b1, 1'b0, 1'b0, "bp second");
    chk("bp held", {24'd0, bus0.parallel_out}, 32'h11);
    chk("bp overrun", {31'd0, ovr0}, 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "bp clear");
    chk("bp overrun cleared", {31'd0, ovr0}, 32'd0);
    chk("bp drained", {31'd0, bus0.parallel_valid}, 32'd0);

    // Simultaneous drain and fill
    send_word(8'h0F, 1'b1, 1'b0, 1'b0, "fill hold");
    send_word(8'h5A, 1'b1, 1'b0, 1'b1, "fill swap");
    chk("swap word", {24'd0, bus0.parallel_out}, 32'h5A);
    chk("swap valid", {31'd0, bus0.parallel_valid}, 32'd1);
    chk("swap overrun", {31'd0, ovr0}, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "swap drain");

    // sync_clear wins over serial_valid
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "sc partial");
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "sc clear");
    chk("sc bit_count", {29'd0, bc0}, 32'd0);
    send_word(8'hC3, 1'b1, 1'b1, 1'b1, "sc word");
    chk("sc result", {24'd0, bus0.parallel_out}, 32'hC3);

    // Async reset between edges after 5 bits
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "mid bits");
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async reset");
    @(posedge clk);
    #2 reset_n = 1'b1;
    send_word(8'h96, 1'b1, 1'b0, 1'b0, "post reset");
    chk("post reset word", {24'd0, bus0.parallel_out}, 32'h96);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "post reset drain");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 1)), $urandom_range(0, 4) != 0, $urandom_range(0, 30) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 20) == 0, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
